// File: rtl/ulpi_pkg.sv
// Shared ULPI link definitions: TX FSM states, bus constants and RX CMD field layout.
// The system uses the TXCMD and RXCMD layouts to build and decode bytes; the link passes them through unchanged.
package ulpi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TX,
        STOP
    } tx_state_e;

    localparam logic [7:0] ULPI_IDLE       = 8'h00;

    // The top two bits of a TX CMD select the command class.
    localparam logic [7:0] TXCMD_MASK      = 8'hC0;
    localparam logic [7:0] TXCMD_TRANSMIT  = 8'h40;
    localparam logic [7:0] TXCMD_REG_WRITE = 8'h80;
    localparam logic [7:0] TXCMD_REG_READ  = 8'hC0;

    typedef struct packed {
        logic [1:0] rsvd;       // [7:6]
        logic [1:0] rxevent;    // [5:4]
        logic [1:0] vbus;       // [3:2]
        logic [1:0] linestate;  // [1:0]
    } rxcmd_t;

    function automatic rxcmd_t rxcmd_decode(input logic [7:0] b);
        return rxcmd_t'(b);
    endfunction

endpackage

// File: rtl/ulpi_if.sv
// PHY-side ULPI pins: clock from the PHY, shared 8-bit data bus, dir/nxt/stp.
// The link side is the master; the PHY or its model is the slave.
interface ulpi_if;
    logic       clk;
    wire  [7:0] data;
    logic       dir;
    logic       nxt;
    logic       stp;

    modport master (input clk, inout data, input dir, input nxt, output stp);
    modport slave  (output clk, inout data, output dir, output nxt, input stp);
endinterface

// File: rtl/ulpi_link_if.sv
// System-side signals of the ULPI link: reset, transmit command path and receive outputs.
// The system is the master; the link is the slave.
interface ulpi_link_if;
    logic       reset;
    logic [7:0] cmd;
    logic       cmd_strobe;
    logic       cmd_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_cmd_valid;
    logic       tx_abort;

    modport master (output reset, output cmd, output cmd_strobe, input cmd_busy,
                    input rx_data, input rx_valid, input rx_cmd_valid, input tx_abort);
    modport slave  (input reset, input cmd, input cmd_strobe, output cmd_busy,
                    output rx_data, output rx_valid, output rx_cmd_valid, output tx_abort);
endinterface

// File: rtl/ulpi_link_tx.sv
// Transmit side of the ULPI link: one-byte holding register, IDLE/TX/STOP FSM, stp and abort.
// tx_data is the value the top level puts on the bus whenever the link owns it.
module ulpi_link_tx
    import ulpi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dir,
    input  logic       dir_prev,
    input  logic       nxt,
    input  logic [7:0] cmd,
    input  logic       cmd_strobe,
    output logic       cmd_busy,
    output logic       stp,
    output logic       tx_abort,
    output logic [7:0] tx_data
);

    tx_state_e  state;
    logic [7:0] hold;
    logic       hold_full;
    logic       consume;
    logic       accept;
    logic       dir_rise;

    // NOTE: always_comb takes blocking assignments and drives every output on every path, so no latch is inferred.
    always_comb begin
        consume  = (state == TX) && nxt && !dir;
        cmd_busy = hold_full && !consume;
        accept   = cmd_strobe && !cmd_busy;
        dir_rise = dir && !dir_prev;
        tx_data  = (state == TX) ? hold : ULPI_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only; hold is a single byte, so it is reset as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= ULPI_IDLE;
            hold_full <= 1'b0;
            stp       <= 1'b0;
            tx_abort  <= 1'b0;
        end else begin
            tx_abort <= 1'b0;
            if (dir_rise && state != IDLE) begin
                // The PHY took the bus mid-packet. It wins over a same-edge nxt, and the pending byte is dropped.
                state     <= IDLE;
                hold_full <= 1'b0;
                stp       <= 1'b0;
                tx_abort  <= 1'b1;
            end else begin
                if (accept) begin
                    hold      <= cmd;
                    hold_full <= 1'b1;
                end
                case (state)
                    IDLE: if (hold_full && !dir && !dir_prev) state <= TX;
                    TX: begin
                        if (consume && !accept) begin
                            hold_full <= 1'b0;
                            state     <= STOP;
                            stp       <= 1'b1;
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        stp   <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ulpi_link.sv
// Link-side ULPI controller: bus turnaround, RX byte capture, and the transmit engine.
// The link drives the bus only after dir has been low for a full cycle; it releases the bus as soon as dir rises.
module ulpi_link
    import ulpi_pkg::*;
(
    ulpi_if.master      ulpi,
    ulpi_link_if.slave  sys
);

    logic       dir_prev;
    logic       drive_en;
    logic [7:0] tx_data;

    always_ff @(posedge ulpi.clk or negedge sys.reset) begin
        if (!sys.reset) begin
            dir_prev         <= 1'b0;
            sys.rx_data      <= ULPI_IDLE;
            sys.rx_valid     <= 1'b0;
            sys.rx_cmd_valid <= 1'b0;
        end else begin
            dir_prev         <= ulpi.dir;
            sys.rx_valid     <= 1'b0;
            sys.rx_cmd_valid <= 1'b0;
            // Capture is skipped in the turnaround cycle after dir rises.
            if (ulpi.dir && dir_prev) begin
                sys.rx_data      <= ulpi.data;
                sys.rx_valid     <= ulpi.nxt;
                sys.rx_cmd_valid <= !ulpi.nxt;
            end
        end
    end

    assign drive_en  = !ulpi.dir && !dir_prev;
    assign ulpi.data = drive_en ? tx_data : 8'hzz;

    ulpi_link_tx u_tx (
        .clk        (ulpi.clk),
        .rst_n      (sys.reset),
        .dir        (ulpi.dir),
        .dir_prev   (dir_prev),
        .nxt        (ulpi.nxt),
        .cmd        (sys.cmd),
        .cmd_strobe (sys.cmd_strobe),
        .cmd_busy   (sys.cmd_busy),
        .stp        (ulpi.stp),
        .tx_abort   (sys.tx_abort),
        .tx_data    (tx_data)
    );

endmodule

// File: tb/tb_ulpi_link.sv
// Directed bench for ulpi_link: turnaround, RX burst, single and back-to-back TX, abort, async reset.
// Inputs change 1 ns after the rising edge, and outputs are sampled there as well.
module tb_ulpi_link;
    import ulpi_pkg::*;

    ulpi_if      ubus ();
    ulpi_link_if sbus ();

    logic       phy_oe;
    logic [7:0] phy_drv;
    int         n_tests = 0;
    int         n_fail  = 0;

    assign ubus.data = phy_oe ? phy_drv : 8'hzz;

    ulpi_link dut (
        .ulpi (ubus),
        .sys  (sbus)
    );

    initial ubus.clk = 1'b0;
    always #5 ubus.clk = ~ubus.clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ubus.clk);
        #1;
    endtask

    logic [7:0] rx_bytes [10] = '{8'h42, 8'h11, 8'h9c, 8'he7, 8'h3d, 8'hf0, 8'h80, 8'h05, 8'hbe, 8'h7a};
    logic       rx_nxt   [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] tx6      [6]  = '{8'hc1, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [31:0] nxt_pat      = 32'hb5a3_6d5b;

    initial begin
        int k;
        int exp_idx;

        sbus.reset      = 1'b0;
        sbus.cmd        = 8'h00;
        sbus.cmd_strobe = 1'b0;
        ubus.dir        = 1'b0;
        ubus.nxt        = 1'b0;
        phy_oe          = 1'b0;
        phy_drv         = 8'h00;

        #2;
        check("rst_stp",      ubus.stp,          8'h00);
        check("rst_busy",     sbus.cmd_busy,     8'h00);
        check("rst_rx_valid", sbus.rx_valid,     8'h00);
        check("rst_rx_cmd",   sbus.rx_cmd_valid, 8'h00);
        check("rst_abort",    sbus.tx_abort,     8'h00);
        check("rst_rx_data",  sbus.rx_data,      8'h00);
        check("rst_data",     ubus.data,         8'h00);
        step();
        step();
        sbus.reset = 1'b1;
        step();

        // Turnaround, including a cmd accepted while the PHY owns the bus
        ubus.dir = 1'b1; phy_oe = 1'b1; phy_drv = 8'h99;
        #1 check("ta_release", ubus.data, 8'h99);
        step();
        check("ta_nocap_cmd",  sbus.rx_cmd_valid, 8'h00);
        check("ta_nocap_data", sbus.rx_data,      8'h00);
        phy_drv = 8'h23; ubus.nxt = 1'b0; sbus.cmd = 8'h55; sbus.cmd_strobe = 1'b1;
        #1 check("ta_busy_dir", sbus.cmd_busy, 8'h00);
        step();
        check("ta_rxcmd_valid", sbus.rx_cmd_valid, 8'h01);
        check("ta_rx_valid",    sbus.rx_valid,     8'h00);
        check("ta_rx_data",     sbus.rx_data,      8'h23);
        sbus.cmd_strobe = 1'b0; ubus.dir = 1'b0; phy_oe = 1'b0;
        step();
        check("ta_fall_nocap", sbus.rx_cmd_valid, 8'h00);
        check("ta_fall_idle",  ubus.data,         8'h00);
        check("ta_fall_busy",  sbus.cmd_busy,     8'h01);
        step();
        check("ta_tx_start", ubus.data, 8'h55);
        ubus.nxt = 1'b1;
        #1 check("ta_busy_consume", sbus.cmd_busy, 8'h00);
        step();
        ubus.nxt = 1'b0;
        check("ta_stp",      ubus.stp,  8'h01);
        check("ta_stp_data", ubus.data, 8'h00);
        step();
        check("ta_stp_end", ubus.stp, 8'h00);

        // RX burst: RX CMD, 4 data, RX CMD, 4 data
        ubus.dir = 1'b1; phy_oe = 1'b1; phy_drv = 8'h00;
        step();
        for (int i = 0; i < 10; i++) begin
            phy_drv  = rx_bytes[i];
            ubus.nxt = rx_nxt[i];
            step();
            check($sformatf("rx_data_%0d", i),  sbus.rx_data,      rx_bytes[i]);
            check($sformatf("rx_valid_%0d", i), sbus.rx_valid,     {7'd0, rx_nxt[i]});
            check($sformatf("rx_cmd_%0d", i),   sbus.rx_cmd_valid, {7'd0, !rx_nxt[i]});
        end
        ubus.dir = 1'b0; ubus.nxt = 1'b0; phy_oe = 1'b0;
        step();
        check("rx_end_valid", sbus.rx_valid,     8'h00);
        check("rx_end_cmd",   sbus.rx_cmd_valid, 8'h00);
        step();

        // Single-byte TX with one wait cycle
        sbus.cmd = 8'h41; sbus.cmd_strobe = 1'b1;
        step();
        sbus.cmd_strobe = 1'b0;
        check("tx1_busy_full", sbus.cmd_busy, 8'h01);
        step();
        check("tx1_cyc1", ubus.data, 8'h41);
        check("tx1_stp0", ubus.stp,  8'h00);
        step();
        check("tx1_wait", ubus.data, 8'h41);
        ubus.nxt = 1'b1;
        step();
        ubus.nxt = 1'b0;
        check("tx1_stp",      ubus.stp,  8'h01);
        check("tx1_stp_data", ubus.data, 8'h00);
        step();
        check("tx1_idle_stp",  ubus.stp,  8'h00);
        check("tx1_idle_data", ubus.data, 8'h00);

        // Six back-to-back bytes, nxt from a fixed pseudo-random pattern
        sbus.cmd = tx6[0]; sbus.cmd_strobe = 1'b1;
        step();
        k = 1;
        sbus.cmd = tx6[1];
        #1 check("tx6_busy_idle", sbus.cmd_busy, 8'h01);
        step();
        exp_idx = 0;
        for (int c = 0; c < 32 && exp_idx < 6; c++) begin
            check($sformatf("tx6_data_c%0d", c), ubus.data, tx6[exp_idx]);
            check($sformatf("tx6_stp_c%0d", c),  ubus.stp,  8'h00);
            ubus.nxt        = nxt_pat[c];
            sbus.cmd_strobe = (k < 6);
            sbus.cmd        = (k < 6) ? tx6[k] : 8'h00;
            #1 check($sformatf("tx6_busy_c%0d", c), sbus.cmd_busy, {7'd0, !nxt_pat[c]});
            step();
            if (nxt_pat[c]) begin
                exp_idx++;
                if (k < 6) k++;
            end
        end
        ubus.nxt = 1'b0; sbus.cmd_strobe = 1'b0;
        check("tx6_all_sent", 8'(exp_idx), 8'd6);
        check("tx6_stp",      ubus.stp,  8'h01);
        check("tx6_stp_data", ubus.data, 8'h00);
        step();
        check("tx6_stp_end", ubus.stp, 8'h00);
        step();
        check("tx6_stp_once", ubus.stp, 8'h00);

        // Abort: dir and nxt rise together during TX
        sbus.cmd = 8'h4a; sbus.cmd_strobe = 1'b1;
        step();
        sbus.cmd_strobe = 1'b0;
        step();
        check("ab_tx", ubus.data, 8'h4a);
        ubus.dir = 1'b1; ubus.nxt = 1'b1; phy_oe = 1'b1; phy_drv = 8'h30;
        #1;
        check("ab_release", ubus.data,     8'h30);
        check("ab_busy_dir", sbus.cmd_busy, 8'h01);
        step();
        check("ab_pulse",    sbus.tx_abort, 8'h01);
        check("ab_stp",      ubus.stp,      8'h00);
        check("ab_busy",     sbus.cmd_busy, 8'h00);
        check("ab_no_cap",   sbus.rx_valid, 8'h00);
        step();
        check("ab_pulse_end", sbus.tx_abort, 8'h00);
        check("ab_stp2",      ubus.stp,      8'h00);
        check("ab_rx_valid",  sbus.rx_valid, 8'h01);
        check("ab_rx_data",   sbus.rx_data,  8'h30);
        ubus.dir = 1'b0; ubus.nxt = 1'b0; phy_oe = 1'b0;
        step();
        step();
        check("ab_discard", ubus.data,     8'h00);
        check("ab_busy2",   sbus.cmd_busy, 8'h00);
        check("ab_stp3",    ubus.stp,      8'h00);

        // Asynchronous reset in the middle of TX
        sbus.cmd = 8'h6b; sbus.cmd_strobe = 1'b1;
        step();
        sbus.cmd_strobe = 1'b0;
        step();
        check("rs_tx", ubus.data, 8'h6b);
        #2 sbus.reset = 1'b0;
        #1;
        check("rs_stp",      ubus.stp,          8'h00);
        check("rs_busy",     sbus.cmd_busy,     8'h00);
        check("rs_rx_data",  sbus.rx_data,      8'h00);
        check("rs_rx_valid", sbus.rx_valid,     8'h00);
        check("rs_abort",    sbus.tx_abort,     8'h00);
        check("rs_data",     ubus.data,         8'h00);
        step();
        sbus.reset = 1'b1;
        step();
        step();
        check("rs_post_data", ubus.data,     8'h00);
        check("rs_post_busy", sbus.cmd_busy, 8'h00);
        check("rs_post_stp",  ubus.stp,      8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ulpi_link.md
Name: ulpi_link

Overview:
- Link-side ULPI controller between a ULPI PHY (8-bit SDR bus, `dir`/`nxt`/`stp`) and the system.
- Sends system command/data bytes to the PHY with the ULPI transmit handshake, including `stp` generation.
- Captures PHY-driven bytes (RX CMD and packet data) and presents them to the system.
- PHY pins are bundled in interface `ulpi_if`; system-side signals are bundled in interface `ulpi_link_if`.

Parameters:
- none

Ports:
- clk  in  1  ULPI clock; all logic on rising edge (`ulpi_if`)
- reset  in  1  asynchronous, active-low reset (`ulpi_link_if`); logic resets while 0
- data  inout  8  ULPI data bus (`ulpi_if`)
- dir  in  1  PHY owns bus when 1 (`ulpi_if`)
- nxt  in  1  PHY throttle/accept (`ulpi_if`)
- stp  out  1  link end-of-transmit (`ulpi_if`)
- cmd  in  8  byte to transmit (`ulpi_link_if`)
- cmd_strobe  in  1  cmd valid (`ulpi_link_if`)
- cmd_busy  out  1  cmd not accepted this cycle (`ulpi_link_if`)
- rx_data  out  8  last byte captured from PHY
- rx_valid  out  1  one-cycle pulse: rx_data is packet data
- rx_cmd_valid  out  1  one-cycle pulse: rx_data is an RX CMD
- tx_abort  out  1  one-cycle pulse: transmit aborted by PHY

Behaviour:
- Reset values:
  - stp=0, cmd_busy=0, rx_valid=0, rx_cmd_valid=0, tx_abort=0, rx_data=0.
  - Holding register empty; state IDLE.
  - data driven 8'h00 while dir=0.
- Bus ownership:
  - Link drives data only when dir=0 and the previous-cycle dir was also 0.
  - Otherwise data is high-Z.
  - The cycle after any dir edge is a turnaround cycle: no drive, no capture.
  - Idle link drives 8'h00.
- Receive, for each edge with dir=1, dir_prev=1:
  - nxt=0: rx_data<=data, rx_cmd_valid pulses next cycle.
  - nxt=1: rx_data<=data, rx_valid pulses next cycle.
  - Latency: 1 clock from the sampling edge.
- Transmit uses a one-byte holding register.
- cmd_busy: combinational, = hold_full & ~(state==TX & nxt & ~dir).
- cmd accepted at an edge where cmd_strobe=1 and cmd_busy=0: hold<=cmd, hold_full<=1.
- States:
  - IDLE: data=00. If hold_full and dir=0 (not turnaround) -> TX.
  - TX: data=hold.
    - Edge with nxt=1: byte consumed.
    - If a new cmd is accepted the same edge, hold reloads and the state stays TX.
    - Otherwise hold_full<=0 -> STOP.
    - nxt=0: hold byte unchanged (wait state, unlimited).
  - STOP: stp=1, data=00 for exactly one cycle -> IDLE.
- First byte of a packet (TX CMD) is the first cmd accepted from IDLE; it gets no special encoding.
- Abort:
  - dir rising while in TX or STOP -> state IDLE, hold_full<=0, stp=0.
  - tx_abort pulses 1 cycle.
  - The pending byte is discarded.
- cmd_strobe while dir=1 is still accepted into hold (if empty).
  - Transmit begins after the dir falls and the turnaround cycle passes.
- Simultaneous nxt and dir rise: dir wins (abort); the byte is not counted as consumed.
- Reset asserted mid-operation: immediate return to reset values; data released per dir.

Decomposition:
- Package `ulpi_pkg`:
  - state enum {IDLE, TX, STOP}.
  - Constants: ULPI_IDLE=8'h00, TXCMD field masks (8'h40 transmit, 8'h80 reg write, 8'hC0 reg read), RXCMD bit fields (linestate[1:0], vbus[3:2], rxevent[5:4]) for system decoding.
- Natural sub-module: `ulpi_link_tx` (holding register, TX FSM, stp, cmd_busy).
- Receive capture and bus-turnaround logic stay in the top level.

Test Plan:
- Turnaround:
  - Stimulus: dir 0->1, PHY drives 23 next cycle, dir->0.
  - Required: the cycle right after the dir rise is not captured; rx_cmd_valid with rx_data=23; link drives no data until one cycle after the dir fall.
- RX data burst:
  - Stimulus: dir=1, 42 (nxt=0), 4 random bytes (nxt=1), f0 (nxt=0), 4 bytes (nxt=1).
  - Required: rx_cmd_valid for 42 and f0; rx_valid for each of the 8 data bytes, 1-cycle latency, values equal.
- Single-byte TX:
  - Stimulus: strobe cmd=8'h41; PHY asserts nxt on the 2nd TX cycle.
  - Required: data=41 held through the wait cycle; next cycle stp=1, data=00; then idle.
- Six-byte back-to-back TX with random nxt:
  - Required: each byte appears on data in order until nxt; cmd_busy gates the strobe; exactly one stp pulse after byte 6.
- Abort:
  - Stimulus: dir rises during TX.
  - Required: tx_abort pulse, stp stays 0, cmd_busy=0, data released.
- Reset:
  - Stimulus: reset=0 mid-TX.
  - Required: all outputs at reset values asynchronously; hold empty after release.
